rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Produces a binary grant index (3 bits) plus a registered one-hot grant, decoded by a 3-to-8 decoder sub-module.
- Sits in front of shared datapath resources (display digit slot, bus port, LED driver) so that exactly one requester owns the resource at a time.
- Grant is held until the owner releases it, which is the handshake.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 in this revision.
- IDX_W, 3, grant index width (log2 N_REQ).
- MAX_HOLD, 16, cycles an owner may hold the grant before preemption; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high = requester i wants/holds the resource.
- gnt_valid  output  1  registered; a grant is active.
- gnt_idx  output  3  registered; index of current owner; 0 when gnt_valid=0.
- gnt_onehot  output  8  registered; decode of gnt_idx when gnt_valid=1, else 8'h00.
- busy  output  1  combinational; equals gnt_valid.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=8'h00, ptr=0.
  - Reset mid-grant drops the grant at that edge, with no handshake.
- State IDLE:
  - If req!=0, select the first set bit scanning from ptr upward, wrapping 7->0.
  - Next edge: gnt_idx=sel, gnt_valid=1, gnt_onehot=1<<sel, ptr=(sel+1) mod 8, state=GRANT.
  - Latency from req asserted to gnt_valid is 1 cycle.
  - If req==0, remain in IDLE with outputs at their reset values.
- State GRANT:
  - While req[gnt_idx]=1, hold all outputs unchanged. Other req bits are ignored for grant purposes.
  - When req[gnt_idx]=0 (release), arbitrate in the same cycle from ptr over the current req.
    - If any bit is set, grant it directly at the next edge (back-to-back handoff, no idle cycle) and update ptr to sel+1.
    - If none are set, next edge goes to IDLE with gnt_valid=0, gnt_idx=0, gnt_onehot=0.
- Fairness:
  - ptr always points one past the last granted index.
  - A requester that keeps req high waits at most 7 other tenures.
- Simultaneous events:
  - Multiple new requests resolve by rotating priority from ptr.
  - Owner release together with a new request from the same index: not possible in one cycle. A re-request by the owner is treated as a new request at lowest priority, because ptr has already moved past it.
- Wrap-around: sel=7 gives ptr=0.
- Invariants:
  - gnt_onehot is always either 0 or exactly one-hot.
  - gnt_onehot[gnt_idx] = gnt_valid.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A hold counter (width ceil(log2(MAX_HOLD))+1) clears on every new grant and increments each cycle in GRANT.
  - When the counter reaches MAX_HOLD-1 and another req bit (excluding the owner) is set, preempt: next edge grants the next requester from ptr, exactly as on a release.
  - If no other request is pending, the owner keeps the grant and the counter saturates.
- Without the macro: no counter; the owner holds the grant indefinitely until it releases.

Decomposition:
- Package arb_pkg holds:
  - N_REQ and IDX_W constants.
  - State encodings IDLE=1'b0 and GRANT=1'b1.
  - A function for the rotating priority search (req, ptr -> sel, found).
- Sub-module dec_3to8: combinational 3-bit input to 8-bit one-hot output, instantiated once.
  - Its output is ANDed with the next-state valid bit and then registered into gnt_onehot.
- All remaining logic is a two-state FSM plus the ptr register, both in rr_arbiter8.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=8'hFF -> gnt_valid=0, gnt_onehot=8'h00 throughout; after rst falls, 1 cycle later gnt_idx=0 and gnt_onehot=8'h01.
2. Rotation: req=8'hFF, each owner drops its bit for 1 cycle after its grant, then reasserts -> grants go 0,1,2,...,7,0 with back-to-back handoff and no gnt_valid gap.
3. Hold: req=8'h24 (bits 2,5), owner 2 holds for 10 cycles -> gnt_idx=2 stable for 10 cycles; after release, the next edge gives gnt_idx=5 and gnt_onehot=8'h20.
4. Wrap and idle: ptr=7 state, req=8'h81 -> grant 7 then 0; all req drop -> next edge gnt_valid=0, gnt_onehot=8'h00.
5. Reset mid-grant: owner 3 granted, assert rst for one cycle -> next edge gnt_valid=0 and ptr=0; with req=8'h08 still high, regrant to 3 one cycle after rst deasserts.
6. ARB_TIMEOUT_EN, MAX_HOLD=16:
   - req=8'h03, owner 0 never releases -> preempted to 1 after 16 cycles of grant.
   - req=8'h01 alone -> owner 0 holds indefinitely.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, FSM encoding and the rotating-priority search for the 8-way round-robin arbiter.
// Pure declarations: no latency, no backpressure.
package arb_pkg;

  localparam int N_REQ    = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;
  localparam int HOLD_W   = $clog2(MAX_HOLD) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] sel;
  } pick_t;

  // Scan downward in offset so the last hit written is the one closest to ptr.
  function automatic pick_t rr_search(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr);
    pick_t            p;
    logic [IDX_W-1:0] idx;
    p = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        p.found = 1'b1;
        p.sel   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dec_3to8.sv
// 3-to-8 one-hot decoder; combinational, zero latency, no backpressure.
module dec_3to8 (
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  always_comb begin
    onehot      = 8'h00;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold-until-release grant; 1-cycle req->grant, back-to-back handoff.
// Owner keeps the grant while its req is high; ARB_TIMEOUT_EN adds MAX_HOLD-cycle preemption.
module rr_arbiter8
  import arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  output logic                 gnt_valid,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic [N_REQ-1:0]     gnt_onehot,
  output logic                 busy
);

  state_t             state;
  state_t             nxt_state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   nxt_ptr;
  logic               nxt_valid;
  logic [IDX_W-1:0]   nxt_idx;
  logic [N_REQ-1:0]   dec_out;
  logic [N_REQ-1:0]   nxt_onehot;
  logic [N_REQ-1:0]   cand;
  logic               owner_release;
  logic               arb;
  pick_t              pick;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0]  hold_cnt;
  logic               preempt;
`endif

  always_comb begin
    // The owner's own bit never competes; a re-request lands behind everyone else.
    cand          = (state == GRANT) ? (req & ~gnt_onehot) : req;
    owner_release = (state == GRANT) && !req[gnt_idx];
    arb           = (state == IDLE) || owner_release;
`ifdef ARB_TIMEOUT_EN
    preempt       = (state == GRANT) && req[gnt_idx] && (hold_cnt == HOLD_LAST) && (|cand);
    arb           = arb || preempt;
`endif
    pick          = rr_search(cand, ptr);

    nxt_state = state;
    nxt_valid = gnt_valid;
    nxt_idx   = gnt_idx;
    nxt_ptr   = ptr;
    if (arb) begin
      if (pick.found) begin
        nxt_state = GRANT;
        nxt_valid = 1'b1;
        nxt_idx   = pick.sel;
        nxt_ptr   = pick.sel + 3'd1;
      end else begin
        nxt_state = IDLE;
        nxt_valid = 1'b0;
        nxt_idx   = '0;
      end
    end
    nxt_onehot = dec_out & {N_REQ{nxt_valid}};
  end

  dec_3to8 u_dec (
    .idx    (nxt_idx),
    .onehot (dec_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      ptr        <= '0;
    end else begin
      state      <= nxt_state;
      gnt_valid  <= nxt_valid;
      gnt_idx    <= nxt_idx;
      gnt_onehot <= nxt_onehot;
      ptr        <= nxt_ptr;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Saturates at the preemption threshold so a lone owner can hold forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (arb && pick.found) begin
      hold_cnt <= '0;
    end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end
`endif

  assign busy = gnt_valid;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized and directed checks of rr_arbiter8 against a tenure-level reference model.
module tb_rr_arbiter8;

  localparam int TB_MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the resource, where the rotation resumes, how long held.
  int m_v   = 0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  rr_arbiter8 dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_next(input logic r, input logic [7:0] q);
    logic [7:0] c;
    int         found;
    int         sel;
    int         do_arb;
    if (r) begin
      m_v = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      c = q;
      if (m_v != 0) c[m_idx] = 1'b0;
      do_arb = (m_v == 0) || (q[m_idx] == 1'b0);
`ifdef ARB_TIMEOUT_EN
      if (m_v != 0 && q[m_idx] && m_cnt >= TB_MAX_HOLD - 1 && c != 8'h00) do_arb = 1;
`endif
      if (do_arb != 0) begin
        found = 0;
        sel   = 0;
        for (int k = 0; k < 8; k++) begin
          if (found == 0 && c[(m_ptr + k) % 8]) begin
            found = 1;
            sel   = (m_ptr + k) % 8;
          end
        end
        if (found != 0) begin
          m_v = 1; m_idx = sel; m_ptr = (sel + 1) % 8; m_cnt = 0;
        end else begin
          m_v = 0; m_idx = 0;
        end
      end else if (m_cnt < TB_MAX_HOLD - 1) begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q);
    logic [7:0] exp_oh;
    @(negedge clk);
    rst = r;
    req = q;
    model_next(r, q);
    @(posedge clk);
    #1;
    exp_oh = 8'h00;
    if (m_v != 0) exp_oh[m_idx] = 1'b1;
    chk("gnt_valid", 32'(gnt_valid), 32'(m_v));
    chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    chk("gnt_onehot", 32'(gnt_onehot), 32'(exp_oh));
    chk("busy", 32'(busy), 32'(m_v));
    chk("onehot_pop", 32'($countones(gnt_onehot) <= 1), 32'd1);
  endtask

  initial begin
    logic [7:0] q;
    logic       r;

    // Reset held with every requester active
    step(1'b1, 8'hFF);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    step(1'b1, 8'hFF);
    chk("rst_onehot", 32'(gnt_onehot), 32'h00);
    step(1'b0, 8'hFF);
    chk("first_idx", 32'(gnt_idx), 32'd0);
    chk("first_onehot", 32'(gnt_onehot), 32'h01);

    // Full rotation with back-to-back handoff
    for (int k = 1; k <= 8; k++) begin
      q = 8'hFF;
      q[(k - 1) % 8] = 1'b0;
      step(1'b0, q);
      chk("rot_idx", 32'(gnt_idx), 32'(k % 8));
      chk("rot_valid", 32'(gnt_valid), 32'd1);
      step(1'b0, 8'hFF);
    end

    // Owner 2 holds while 5 waits
    step(1'b1, 8'h00);
    step(1'b0, 8'h24);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 8'h24);
      chk("hold_idx", 32'(gnt_idx), 32'd2);
    end
    step(1'b0, 8'h20);
    chk("hold_next_idx", 32'(gnt_idx), 32'd5);
    chk("hold_next_oh", 32'(gnt_onehot), 32'h20);

    // Wrap 7 -> 0, then drain to idle
    step(1'b0, 8'h40);
    chk("wrap_6", 32'(gnt_idx), 32'd6);
    step(1'b0, 8'h81);
    chk("wrap_7", 32'(gnt_idx), 32'd7);
    step(1'b0, 8'h01);
    chk("wrap_0", 32'(gnt_onehot), 32'h01);
    step(1'b0, 8'h00);
    chk("idle_valid", 32'(gnt_valid), 32'd0);
    chk("idle_onehot", 32'(gnt_onehot), 32'h00);

    // Reset in the middle of a tenure
    step(1'b1, 8'h00);
    step(1'b0, 8'h08);
    chk("mid_grant", 32'(gnt_idx), 32'd3);
    step(1'b1, 8'h08);
    chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
    step(1'b0, 8'h08);
    chk("mid_regrant", 32'(gnt_onehot), 32'h08);

    // Long hold by owner 0 with 1 waiting
    step(1'b1, 8'h00);
    step(1'b0, 8'h03);
    chk("long_start", 32'(gnt_idx), 32'd0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < TB_MAX_HOLD - 1; k++) begin
      step(1'b0, 8'h03);
      chk("to_hold", 32'(gnt_idx), 32'd0);
    end
    step(1'b0, 8'h03);
    chk("to_preempt", 32'(gnt_idx), 32'd1);
    step(1'b0, 8'h01);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 8'h01);
      chk("to_alone", 32'(gnt_idx), 32'd0);
    end
`else
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 8'h03);
      chk("no_to_hold", 32'(gnt_idx), 32'd0);
    end
`endif

    // Random traffic: owners mostly keep their bit, occasional reset
    for (int k = 0; k < 800; k++) begin
      q = 8'($urandom);
      if (m_v != 0 && $urandom_range(0, 3) != 0) q[m_idx] = 1'b1;
      if ($urandom_range(0, 7) == 0) q = 8'h00;
      r = ($urandom_range(0, 63) == 0);
      step(r, q);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
